// File: rtl/sbox_pkg.sv
// Shared constants and the per-port pipeline stage record for the S-box BRAM arbiter.
package sbox_pkg;

    localparam int SBOX_AW      = 10;
    localparam int SBOX_DW      = 8;
    localparam int SBOX_LAT     = 3;
    // Wide enough for the largest legal requester count (8).
    localparam int SBOX_IDW_MAX = 3;

    typedef struct packed {
        logic                    valid;
        logic [SBOX_IDW_MAX-1:0] id;
    } stage_t;

endpackage

// File: rtl/sbox_bram_arbiter_rr_pick2.sv
// Round-robin picker: first and second set bit of req, scanning upward from ptr with wrap.
module rr_pick2 #(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] gnt_a,
    output logic [NREQ-1:0] gnt_b,
    output logic [IDW-1:0]  idx_a,
    output logic [IDW-1:0]  idx_b,
    output logic            found_a,
    output logic            found_b
);

    always_comb begin
        logic [IDW-1:0] cand;
        cand    = '0;
        idx_a   = '0;
        idx_b   = '0;
        found_a = 1'b0;
        found_b = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            cand = IDW'((int'(ptr) + k) % NREQ);
            if (req[cand]) begin
                if (!found_a) begin
                    found_a = 1'b1;
                    idx_a   = cand;
                end else if (!found_b) begin
                    found_b = 1'b1;
                    idx_b   = cand;
                end
            end
        end
        gnt_a = found_a ? (NREQ'(1) << idx_a) : '0;
        gnt_b = found_b ? (NREQ'(1) << idx_b) : '0;
    end

endmodule

// File: rtl/sbox_bram_arbiter.sv
// Two-grant round-robin arbiter feeding a dual-port S-box BRAM with output register;
// results return a fixed SBOX_LAT cycles after the handshake, tagged with the requester ID.
module sbox_bram_arbiter
    import sbox_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [NREQ*SBOX_AW-1:0] req_addr,
    output logic [NREQ-1:0]         req_ready,
    output logic                    rsp_a_valid,
    output logic                    rsp_b_valid,
    output logic [IDW-1:0]          rsp_a_id,
    output logic [IDW-1:0]          rsp_b_id,
    output logic [SBOX_DW-1:0]      rsp_a_data,
    output logic [SBOX_DW-1:0]      rsp_b_data,
    output logic [SBOX_AW-1:0]      bram_addra,
    output logic [SBOX_AW-1:0]      bram_addrb,
    output logic                    bram_en,
    output logic                    bram_rst,
    input  logic [SBOX_DW-1:0]      bram_doa,
    input  logic [SBOX_DW-1:0]      bram_dob
);

    logic [NREQ-1:0]    req_eff;
    logic [NREQ-1:0]    gnt_a;
    logic [NREQ-1:0]    gnt_b;
    logic [IDW-1:0]     idx_a;
    logic [IDW-1:0]     idx_b;
    logic               found_a;
    logic               found_b;
    logic [SBOX_AW-1:0] addr_arr [NREQ];

    logic [IDW-1:0]     rr_ptr_q, rr_ptr_d;
    logic [SBOX_AW-1:0] addr_a_q, addr_a_d;
    logic [SBOX_AW-1:0] addr_b_q, addr_b_d;
    stage_t             st_a_q [SBOX_LAT];
    stage_t             st_a_d [SBOX_LAT];
    stage_t             st_b_q [SBOX_LAT];
    stage_t             st_b_d [SBOX_LAT];

    // No grant may be issued in a reset cycle.
    assign req_eff = rst ? '0 : req_valid;

    rr_pick2 #(.NREQ(NREQ), .IDW(IDW)) u_pick (
        .req     (req_eff),
        .ptr     (rr_ptr_q),
        .gnt_a   (gnt_a),
        .gnt_b   (gnt_b),
        .idx_a   (idx_a),
        .idx_b   (idx_b),
        .found_a (found_a),
        .found_b (found_b)
    );

    assign req_ready = gnt_a | gnt_b;

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_addr
            assign addr_arr[gi] = req_addr[gi*SBOX_AW +: SBOX_AW];
        end
    endgenerate

    always_comb begin
        logic [IDW-1:0] last;
        last     = found_b ? idx_b : idx_a;
        rr_ptr_d = rr_ptr_q;
        if (found_a) begin
            rr_ptr_d = (last == IDW'(NREQ - 1)) ? '0 : last + 1'b1;
        end
        addr_a_d = found_a ? addr_arr[idx_a] : '0;
        addr_b_d = found_b ? addr_arr[idx_b] : '0;
    end

    generate
        for (genvar gi = 0; gi < SBOX_LAT; gi++) begin : g_stage
            if (gi == 0) begin : g_head
                assign st_a_d[gi] = '{valid: found_a, id: SBOX_IDW_MAX'(idx_a)};
                assign st_b_d[gi] = '{valid: found_b, id: SBOX_IDW_MAX'(idx_b)};
            end else begin : g_shift
                assign st_a_d[gi] = st_a_q[gi-1];
                assign st_b_d[gi] = st_b_q[gi-1];
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q <= '0;
            addr_a_q <= '0;
            addr_b_q <= '0;
            for (int i = 0; i < SBOX_LAT; i++) begin
                st_a_q[i] <= '0;
                st_b_q[i] <= '0;
            end
        end else begin
            rr_ptr_q <= rr_ptr_d;
            addr_a_q <= addr_a_d;
            addr_b_q <= addr_b_d;
            for (int i = 0; i < SBOX_LAT; i++) begin
                st_a_q[i] <= st_a_d[i];
                st_b_q[i] <= st_b_d[i];
            end
        end
    end

    // EN covers the array-read stage and REGCE the output-register stage; both share one pin.
    always_comb begin
        bram_en = 1'b0;
        for (int i = 0; i < SBOX_LAT - 1; i++) begin
            bram_en = bram_en | st_a_q[i].valid | st_b_q[i].valid;
        end
    end

    assign bram_addra  = addr_a_q;
    assign bram_addrb  = addr_b_q;
    assign bram_rst    = rst;

    assign rsp_a_valid = st_a_q[SBOX_LAT-1].valid;
    assign rsp_b_valid = st_b_q[SBOX_LAT-1].valid;
    assign rsp_a_id    = IDW'(st_a_q[SBOX_LAT-1].id);
    assign rsp_b_id    = IDW'(st_b_q[SBOX_LAT-1].id);
    assign rsp_a_data  = rsp_a_valid ? bram_doa : '0;
    assign rsp_b_data  = rsp_b_valid ? bram_dob : '0;

endmodule

// File: tb/tb_sbox_bram_arbiter.sv
// Directed and randomised checks of sbox_bram_arbiter against a behavioural S-box BRAM.
module tb_sbox_bram_arbiter;

    localparam int NREQ = 4;
    localparam int IDW  = 2;

    logic              clk;
    logic              rst;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ*10-1:0] req_addr;
    logic [NREQ-1:0]   req_ready;
    logic              rsp_a_valid, rsp_b_valid;
    logic [IDW-1:0]    rsp_a_id, rsp_b_id;
    logic [7:0]        rsp_a_data, rsp_b_data;
    logic [9:0]        bram_addra, bram_addrb;
    logic              bram_en, bram_rst;
    logic [7:0]        bram_doa, bram_dob;

    int n_checks = 0;
    int n_fail   = 0;

    sbox_bram_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_addr    (req_addr),
        .req_ready   (req_ready),
        .rsp_a_valid (rsp_a_valid),
        .rsp_b_valid (rsp_b_valid),
        .rsp_a_id    (rsp_a_id),
        .rsp_b_id    (rsp_b_id),
        .rsp_a_data  (rsp_a_data),
        .rsp_b_data  (rsp_b_data),
        .bram_addra  (bram_addra),
        .bram_addrb  (bram_addrb),
        .bram_en     (bram_en),
        .bram_rst    (bram_rst),
        .bram_doa    (bram_doa),
        .bram_dob    (bram_dob)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in for the x26 table: known entries exact, others an arbitrary fixed mapping.
    function automatic logic [7:0] sbox_model(input logic [9:0] a);
        case (a)
            10'h000: return 8'h00;
            10'h01F: return 8'hAC;
            10'h03F: return 8'h6C;
            default: return a[7:0] ^ {a[9:8], 6'h15};
        endcase
    endfunction

    // Dual-port BRAM with output register; EN and REGCE tied together.
    logic [7:0] lat_a, lat_b;
    always @(posedge clk) begin
        if (bram_en) begin
            lat_a <= sbox_model(bram_addra);
            lat_b <= sbox_model(bram_addrb);
        end
        if (bram_rst) begin
            bram_doa <= 8'h00;
            bram_dob <= 8'h00;
        end else if (bram_en) begin
            bram_doa <= lat_a;
            bram_dob <= lat_b;
        end
    end

    logic [42:0] all_outs;
    assign all_outs = {rsp_a_valid, rsp_b_valid, rsp_a_id, rsp_b_id, rsp_a_data, rsp_b_data,
                       bram_addra, bram_addrb, bram_en};

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic set_addr(input int i, input logic [9:0] a);
        req_addr[i*10 +: 10] = a;
    endtask

    // Random-phase state
    logic [NREQ-1:0] vld, acc, exp_ready;
    logic [9:0]      raddr [NREQ];
    logic            ev_a [4], ev_b [4];
    logic [1:0]      eid_a [4], eid_b [4];
    logic [7:0]      ed_a [4], ed_b [4];
    int              waitc [NREQ];

    initial begin
        rst       = 1'b1;
        req_valid = 4'hF;
        req_addr  = '0;
        for (int i = 0; i < NREQ; i++) set_addr(i, 10'h03F);

        // Reset held with requests pending: no grants, all outputs quiet.
        for (int c = 0; c < 3; c++) begin
            next();
            #1;
            chk("rst_ready", req_ready, 0);
            chk("rst_outs", all_outs, 0);
            chk("rst_bram_rst", bram_rst, 1);
        end

        rst       = 1'b0;
        req_valid = '0;
        for (int c = 0; c < 20; c++) begin
            next();
            #1;
            chk("idle_outs", {req_ready, all_outs, bram_rst}, 0);
        end

        // Single requester 2
        next();
        req_valid = 4'b0100;
        set_addr(2, 10'h01F);
        #1;
        chk("single_ready", req_ready, 4'b0100);
        next();
        req_valid = '0;
        #1;
        chk("single_addr", {bram_addra, bram_addrb, bram_en}, {10'h01F, 10'h000, 1'b1});
        next();
        #1;
        chk("single_early", {rsp_a_valid, rsp_b_valid}, 0);
        next();
        #1;
        chk("single_rsp_a", {rsp_a_valid, rsp_a_id, rsp_a_data}, {1'b1, 2'd2, 8'hAC});
        chk("single_rsp_b", {rsp_b_valid, rsp_b_id, rsp_b_data}, 0);
        next();
        #1;
        chk("single_drain", {rsp_a_valid, rsp_b_valid, bram_en}, 0);

        // Reset pulse to restart the pointer at 0
        next();
        rst = 1'b1;
        next();
        rst = 1'b0;

        // All four valid: grants alternate {0,1}, {2,3}
        for (int k = 0; k < 7; k++) begin
            next();
            req_valid = 4'hF;
            for (int i = 0; i < NREQ; i++) set_addr(i, 10'h03F);
            #1;
            chk("all4_ready", req_ready, (k % 2 == 0) ? 4'b0011 : 4'b1100);
            if (k >= 1) chk("all4_addr", {bram_addra, bram_addrb}, {10'h03F, 10'h03F});
            if (k >= 3) begin
                chk("all4_rsp_a", {rsp_a_valid, rsp_a_id, rsp_a_data},
                    {1'b1, ((k - 3) % 2 == 0) ? 2'd0 : 2'd2, 8'h6C});
                chk("all4_rsp_b", {rsp_b_valid, rsp_b_id, rsp_b_data},
                    {1'b1, ((k - 3) % 2 == 0) ? 2'd1 : 2'd3, 8'h6C});
            end else begin
                chk("all4_early", {rsp_a_valid, rsp_b_valid}, 0);
            end
        end

        // Pointer now 2: requesters 1 and 3 -> A gets 3, B gets 1
        next();
        req_valid = 4'b1010;
        set_addr(1, 10'h001);
        set_addr(3, 10'h003);
        #1;
        chk("p2_ready", req_ready, 4'b1010);
        chk("p2_tail_a", {rsp_a_valid, rsp_a_id, rsp_a_data}, {1'b1, 2'd0, 8'h6C});
        chk("p2_tail_b", {rsp_b_valid, rsp_b_id, rsp_b_data}, {1'b1, 2'd1, 8'h6C});
        next();
        set_addr(1, 10'h01F);
        set_addr(3, 10'h03F);
        #1;
        chk("p2_ready2", req_ready, 4'b1010);
        chk("p2_addr", {bram_addra, bram_addrb}, {10'h003, 10'h001});
        next();
        req_valid = '0;
        #1;
        chk("p2_addr2", {bram_addra, bram_addrb, req_ready}, {10'h03F, 10'h01F, 4'b0000});
        next();
        #1;
        chk("p2_rsp_a", {rsp_a_valid, rsp_a_id, rsp_a_data}, {1'b1, 2'd3, sbox_model(10'h003)});
        chk("p2_rsp_b", {rsp_b_valid, rsp_b_id, rsp_b_data}, {1'b1, 2'd1, sbox_model(10'h001)});
        next();
        #1;
        chk("p2_rsp_a2", {rsp_a_valid, rsp_a_id, rsp_a_data}, {1'b1, 2'd3, 8'h6C});
        chk("p2_rsp_b2", {rsp_b_valid, rsp_b_id, rsp_b_data}, {1'b1, 2'd1, 8'hAC});
        next();
        #1;
        chk("p2_drain", {rsp_a_valid, rsp_b_valid, bram_en}, 0);

        // Reset one cycle after two grants: those lookups vanish
        next();
        req_valid = 4'hF;
        for (int i = 0; i < NREQ; i++) set_addr(i, 10'h01F);
        #1;
        chk("mid_ready", req_ready, 4'b1100);
        next();
        req_valid = '0;
        rst       = 1'b1;
        #1;
        chk("mid_rst_ready", req_ready, 0);
        next();
        rst = 1'b0;
        #1;
        chk("mid_after_rst", all_outs, 0);
        for (int c = 0; c < 2; c++) begin
            next();
            #1;
            chk("mid_dropped", {rsp_a_valid, rsp_b_valid}, 0);
        end
        next();
        req_valid = 4'b0001;
        set_addr(0, 10'h03F);
        #1;
        chk("mid_new_ready", req_ready, 4'b0001);
        next();
        req_valid = '0;
        #1;
        chk("mid_new_addr", bram_addra, 10'h03F);
        next();
        #1;
        chk("mid_new_early", rsp_a_valid, 0);
        next();
        #1;
        chk("mid_new_rsp", {rsp_a_valid, rsp_a_id, rsp_a_data, rsp_b_valid}, {1'b1, 2'd0, 8'h6C, 1'b0});

        // Random traffic with model arbiter and positional scoreboard
        next();
        rst = 1'b1;
        next();
        rst = 1'b0;
        for (int s = 0; s < 4; s++) begin
            ev_a[s] = 1'b0; ev_b[s] = 1'b0;
            eid_a[s] = '0;  eid_b[s] = '0;
            ed_a[s] = '0;   ed_b[s] = '0;
        end
        for (int i = 0; i < NREQ; i++) begin
            waitc[i] = 0;
            raddr[i] = '0;
        end
        vld = '0;
        acc = '0;
        begin
            int m_ptr, ma, mb, idx, maxw, s_now, s_new;
            logic ma_f, mb_f;
            m_ptr = 0;
            for (int cyc = 0; cyc < 10000; cyc++) begin
                next();
                for (int i = 0; i < NREQ; i++) begin
                    if (!vld[i] || acc[i]) begin
                        vld[i]   = ($urandom_range(0, 99) < 55);
                        raddr[i] = 10'($urandom_range(0, 1023));
                    end
                    set_addr(i, raddr[i]);
                end
                req_valid = vld;
                #1;
                ma_f = 1'b0; mb_f = 1'b0; ma = 0; mb = 0;
                for (int k = 0; k < NREQ; k++) begin
                    idx = (m_ptr + k) % NREQ;
                    if (vld[idx]) begin
                        if (!ma_f) begin ma_f = 1'b1; ma = idx; end
                        else if (!mb_f) begin mb_f = 1'b1; mb = idx; end
                    end
                end
                exp_ready = '0;
                if (ma_f) exp_ready[ma] = 1'b1;
                if (mb_f) exp_ready[mb] = 1'b1;
                chk("rnd_ready", req_ready, exp_ready);

                s_now = cyc % 4;
                chk("rnd_rsp_a", {rsp_a_valid, rsp_a_id, rsp_a_data}, {ev_a[s_now], eid_a[s_now], ed_a[s_now]});
                chk("rnd_rsp_b", {rsp_b_valid, rsp_b_id, rsp_b_data}, {ev_b[s_now], eid_b[s_now], ed_b[s_now]});

                s_new = (cyc + 3) % 4;
                ev_a[s_new]  = ma_f;
                eid_a[s_new] = ma_f ? 2'(ma) : 2'd0;
                ed_a[s_new]  = ma_f ? sbox_model(raddr[ma]) : 8'h00;
                ev_b[s_new]  = mb_f;
                eid_b[s_new] = mb_f ? 2'(mb) : 2'd0;
                ed_b[s_new]  = mb_f ? sbox_model(raddr[mb]) : 8'h00;
                if (ma_f) m_ptr = ((mb_f ? mb : ma) + 1) % NREQ;

                acc  = req_valid & req_ready;
                maxw = 0;
                for (int i = 0; i < NREQ; i++) begin
                    waitc[i] = (vld[i] && !req_ready[i]) ? waitc[i] + 1 : 0;
                    if (waitc[i] > maxw) maxw = waitc[i];
                end
                chk("rnd_fair", (maxw > 2), 0);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
